reset_sequencer_mc: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/reset_lock_filter.sv | 32 +++
 rtl/reset_sequencer_mc.sv | 185 ++++++++++++++++++
 tb/tb_reset_sequencer_mc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the multi-channel reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_OK,
      RELEASE,
      RUN,
      FAULT
   } seq_state_t;

   localparam int FCNT_W = 8;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/reset_lock_filter.sv
// PLL lock qualifier: all lock bits must stay high for LOCK_FILTER cycles.
module reset_lock_filter
   import reset_seq_pkg::*;
#(
   parameter int NUM_PLL     = 2,
   parameter int LOCK_FILTER = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM_PLL-1:0] pll_lock,
   output logic               lock_ok
);

   localparam int LFW = cnt_width(LOCK_FILTER);
   localparam logic [LFW-1:0] LF_MAX = LFW'(LOCK_FILTER);

   logic [LFW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!(&pll_lock)) begin
         count <= '0;
      end else if (enable && count != LF_MAX) begin
         count <= count + LFW'(1);
      end
   end

   assign lock_ok = (count == LF_MAX);

endmodule

// File: rtl/reset_sequencer_mc.sv
// Ordered multi-channel fabric reset release with fault re-sequencing.
// Optional per-channel software reset: RESET_SEQUENCER_SW_RST_EN.
module reset_sequencer_mc
   import reset_seq_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int NUM_PLL     = 2,
   parameter int NUM_BANK    = 2,
   parameter int LOCK_FILTER = 8,
   parameter int RELEASE_GAP = 16,
   parameter int PD_HOLD     = 4
) (
   input  logic                CLK,
   input  logic                EXT_RST_N,
   input  logic                INIT_DONE,
   input  logic [NUM_BANK-1:0] BANK_VDDI_STATUS,
   input  logic [NUM_PLL-1:0]  PLL_LOCK,
`ifdef RESET_SEQUENCER_SW_RST_EN
   input  logic [NUM_CH-1:0]   SW_RST_REQ,
`endif
   output logic [NUM_CH-1:0]   FABRIC_RESET_N,
   output logic                PLL_POWERDOWN_B,
   output logic                SEQ_DONE,
   output logic [FCNT_W-1:0]   FAULT_CNT
);

   localparam int GW = cnt_width(RELEASE_GAP);
   localparam int CW = cnt_width(NUM_CH);
   localparam int PW = cnt_width(PD_HOLD);
   localparam logic [GW-1:0] GAP_LOAD = GW'(RELEASE_GAP - 1);
   localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

   seq_state_t        state, state_nx;
   logic [NUM_CH-1:0] rel, rel_nx;
   logic              done, done_nx;
   logic [FCNT_W-1:0] fcnt, fcnt_nx;
   logic [GW-1:0]     gap, gap_nx;
   logic [CW-1:0]     idx, idx_nx;
   logic              pd_b;
   logic [PW-1:0]     pd_cnt;
   logic              lock_ok;
   logic              ok;
   logic              fault;

`ifdef RESET_SEQUENCER_SW_RST_EN
   logic [GW-1:0]     swc    [NUM_CH];
   logic [GW-1:0]     swc_nx [NUM_CH];
   logic [NUM_CH-1:0] hold, hold_nx;
`endif

   reset_lock_filter #(
      .NUM_PLL     (NUM_PLL),
      .LOCK_FILTER (LOCK_FILTER)
   ) u_lock (
      .clk      (CLK),
      .rst_n    (EXT_RST_N),
      .enable   (pd_b),
      .pll_lock (PLL_LOCK),
      .lock_ok  (lock_ok)
   );

   // PLLs stay powered down for PD_HOLD edges after reset is released
   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         pd_cnt <= '0;
         pd_b   <= 1'b0;
      end else if (!pd_b) begin
         pd_cnt <= pd_cnt + PW'(1);
         pd_b   <= (pd_cnt == PW'(PD_HOLD - 1));
      end
   end

   assign ok    = INIT_DONE & (&BANK_VDDI_STATUS) & lock_ok;
   assign fault = !ok && (state == RELEASE || state == RUN);

   always_comb begin
      state_nx = state;
      rel_nx   = rel;
      done_nx  = done;
      fcnt_nx  = fcnt;
      gap_nx   = gap;
      idx_nx   = idx;
`ifdef RESET_SEQUENCER_SW_RST_EN
      swc_nx   = swc;
      hold_nx  = hold;
`endif
      if (fault) begin
         state_nx = FAULT;
         rel_nx   = '0;
         done_nx  = 1'b0;
         idx_nx   = '0;
         fcnt_nx  = (fcnt == '1) ? fcnt : fcnt + FCNT_W'(1);
`ifdef RESET_SEQUENCER_SW_RST_EN
         hold_nx  = '0;
`endif
      end else begin
         unique case (state)
            WAIT_OK: begin
               if (ok) begin
                  rel_nx[0] = 1'b1;
                  gap_nx    = GAP_LOAD;
                  idx_nx    = CW'(1);
                  if (NUM_CH == 1) begin
                     state_nx = RUN;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (gap != '0) begin
                  gap_nx = gap - GW'(1);
               end else begin
                  rel_nx = rel | (NUM_CH'(1) << idx);
                  if (idx == LAST_CH) begin
                     state_nx = RUN;
                     done_nx  = 1'b1;
                  end else begin
                     idx_nx = idx + CW'(1);
                     gap_nx = GAP_LOAD;
                  end
               end
            end
            RUN: begin
`ifdef RESET_SEQUENCER_SW_RST_EN
               // a repeat request while held restarts that channel's hold
               for (int i = 0; i < NUM_CH; i++) begin
                  if (SW_RST_REQ[i]) begin
                     rel_nx[i]  = 1'b0;
                     hold_nx[i] = 1'b1;
                     swc_nx[i]  = GAP_LOAD;
                  end else if (hold[i]) begin
                     if (swc[i] == '0) begin
                        rel_nx[i]  = 1'b1;
                        hold_nx[i] = 1'b0;
                     end else begin
                        swc_nx[i] = swc[i] - GW'(1);
                     end
                  end
               end
`endif
            end
            FAULT: state_nx = WAIT_OK;
            default: state_nx = WAIT_OK;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         state <= WAIT_OK;
         rel   <= '0;
         done  <= 1'b0;
         fcnt  <= '0;
         gap   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         rel   <= rel_nx;
         done  <= done_nx;
         fcnt  <= fcnt_nx;
         gap   <= gap_nx;
         idx   <= idx_nx;
      end
   end

`ifdef RESET_SEQUENCER_SW_RST_EN
   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         hold <= '0;
         for (int i = 0; i < NUM_CH; i++) swc[i] <= '0;
      end else begin
         hold <= hold_nx;
         for (int i = 0; i < NUM_CH; i++) swc[i] <= swc_nx[i];
      end
   end
`endif

   assign FABRIC_RESET_N  = rel;
   assign PLL_POWERDOWN_B = pd_b;
   assign SEQ_DONE        = done;
   assign FAULT_CNT       = fcnt;

endmodule

// File: tb/tb_reset_sequencer_mc.sv
// Bench for reset_sequencer_mc: directed timing checks plus random run vs model.
module tb_reset_sequencer_mc;

   localparam int NUM_CH   = 4;
   localparam int NUM_PLL  = 2;
   localparam int NUM_BANK = 2;
   localparam int LF       = 8;
   localparam int GAP      = 16;
   localparam int PDH      = 4;
`ifdef RESET_SEQUENCER_SW_RST_EN
   localparam bit SW_EN = 1'b1;
`else
   localparam bit SW_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic                init_done;
   logic [NUM_BANK-1:0] bank;
   logic [NUM_PLL-1:0]  lock;
   logic [NUM_CH-1:0]   sw_req;
   logic [NUM_CH-1:0]   fab_n;
   logic                pd_b;
   logic                done;
   logic [7:0]          fcnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   reset_sequencer_mc #(
      .NUM_CH      (NUM_CH),
      .NUM_PLL     (NUM_PLL),
      .NUM_BANK    (NUM_BANK),
      .LOCK_FILTER (LF),
      .RELEASE_GAP (GAP),
      .PD_HOLD     (PDH)
   ) dut (
      .CLK              (clk),
      .EXT_RST_N        (rst_n),
      .INIT_DONE        (init_done),
      .BANK_VDDI_STATUS (bank),
      .PLL_LOCK         (lock),
`ifdef RESET_SEQUENCER_SW_RST_EN
      .SW_RST_REQ       (sw_req),
`endif
      .FABRIC_RESET_N   (fab_n),
      .PLL_POWERDOWN_B  (pd_b),
      .SEQ_DONE         (done),
      .FAULT_CNT        (fcnt)
   );

   // reference model: phase 0 idle, 1 sequencing/running, 2 fault recovery
   int m_now = 0;
   int m_cyc = 0;
   int m_pd_edges, m_lockrun, m_phase, m_t0, m_rel, m_fcnt;
   bit m_pdb;
   int sw_at [NUM_CH];
   int first_pd;
   int first_ch [NUM_CH];
   int first_done;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
                  $time);
      end
   endtask

   function automatic logic [NUM_CH-1:0] exp_mask();
      logic [NUM_CH-1:0] e;
      for (int i = 0; i < NUM_CH; i++)
         e[i] = (i < m_rel) && !(m_now < sw_at[i]);
      return e;
   endfunction

   task automatic model_edge();
      bit ok;
      bit pdb_old;
      m_now++;
      if (!rst_n) begin
         m_pd_edges = 0;
         m_pdb      = 1'b0;
         m_lockrun  = 0;
         m_phase    = 0;
         m_rel      = 0;
         m_fcnt     = 0;
         m_cyc      = 0;
         for (int i = 0; i < NUM_CH; i++) sw_at[i] = 0;
         return;
      end
      m_cyc++;
      ok      = init_done && (&bank) && (m_lockrun == LF);
      pdb_old = m_pdb;
      case (m_phase)
         1: begin
            if (!ok) begin
               m_phase = 2;
               m_rel   = 0;
               m_fcnt  = (m_fcnt < 255) ? m_fcnt + 1 : 255;
               for (int i = 0; i < NUM_CH; i++) sw_at[i] = 0;
            end else begin
               if (SW_EN && m_rel == NUM_CH)
                  for (int i = 0; i < NUM_CH; i++)
                     if (sw_req[i]) sw_at[i] = m_now + GAP;
               m_rel = 1 + (m_now - m_t0) / GAP;
               if (m_rel > NUM_CH) m_rel = NUM_CH;
            end
         end
         2: m_phase = 0;
         default: begin
            if (ok) begin
               m_phase = 1;
               m_t0    = m_now;
               m_rel   = 1;
            end
         end
      endcase
      if (!(&lock)) m_lockrun = 0;
      else if (pdb_old && m_lockrun < LF) m_lockrun++;
      m_pd_edges++;
      if (m_pd_edges >= PDH) m_pdb = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("fabric_reset_n", 32'(fab_n), 32'(exp_mask()));
      chk("pll_powerdown_b", 32'(pd_b), 32'(m_pdb));
      chk("seq_done", 32'(done), 32'(m_rel == NUM_CH));
      chk("fault_cnt", 32'(fcnt), 32'(m_fcnt));
      if (m_cyc == 0) begin
         first_pd   = -1;
         first_done = -1;
         for (int i = 0; i < NUM_CH; i++) first_ch[i] = -1;
      end else begin
         if (pd_b && first_pd < 0) first_pd = m_cyc;
         if (done && first_done < 0) first_done = m_cyc;
         for (int i = 0; i < NUM_CH; i++)
            if (fab_n[i] && first_ch[i] < 0) first_ch[i] = m_cyc;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int lowcnt;
      int done_lost;
      rst_n     = 1'b0;
      init_done = 1'b0;
      bank      = '0;
      lock      = '0;
      sw_req    = '0;
      repeat (3) tick();

      // clean power-up: reset edge is cycle 0
      init_done = 1'b1;
      bank      = '1;
      lock      = '1;
      pulse_reset();
      repeat (70) tick();
      chk("t_pd_rise", 32'(first_pd), 32'(PDH));
      for (int i = 0; i < NUM_CH; i++)
         chk("t_ch_release", 32'(first_ch[i]), 32'(PDH + LF + 1 + i * GAP));
      chk("t_seq_done", 32'(first_done), 32'(PDH + LF + 1 + (NUM_CH - 1) * GAP));

      // one-cycle lock glitch sampled on edge 9 restarts the filter
      pulse_reset();
      repeat (8) tick();
      lock[1] = 1'b0;
      tick();
      lock[1] = 1'b1;
      repeat (70) tick();
      chk("glitch_ch0", 32'(first_ch[0]), 32'(9 + LF + 1));

      // bank supply loss after ch1 release
      pulse_reset();
      repeat (30) tick();
      bank[0] = 1'b0;
      tick();
      chk("bank_fault_bits", 32'(fab_n), 32'h0);
      chk("bank_fault_cnt", 32'(fcnt), 32'd1);
      repeat (3) tick();
      bank[0] = 1'b1;
      repeat (80) tick();
      chk("resequenced", 32'(done), 32'd1);

      // two more faults in RUN, then a one-cycle external reset
      repeat (2) begin
         init_done = 1'b0;
         tick();
         init_done = 1'b1;
         repeat (70) tick();
      end
      chk("fault_cnt_3", 32'(fcnt), 32'd3);
      pulse_reset();
      chk("rst_bits", 32'(fab_n), 32'h0);
      chk("rst_fcnt", 32'(fcnt), 32'd0);
      chk("rst_pd", 32'(pd_b), 32'd0);
      repeat (70) tick();
      chk("rst_pd_low", 32'(first_pd), 32'(PDH));

      // saturation of the fault counter
      for (int k = 0; k < 300; k++) begin
         init_done = 1'b0;
         tick();
         init_done = 1'b1;
         repeat (2) tick();
      end
      chk("fault_sat", 32'(fcnt), 32'd255);
      repeat (70) tick();

`ifdef RESET_SEQUENCER_SW_RST_EN
      // software reset of channel 2 only
      sw_req = 4'b0100;
      tick();
      sw_req    = '0;
      lowcnt    = (fab_n == 4'b1011) ? 1 : 0;
      done_lost = done ? 0 : 1;
      repeat (24) begin
         tick();
         if (fab_n == 4'b1011) lowcnt++;
         if (!done) done_lost++;
      end
      chk("sw_low_cycles", 32'(lowcnt), 32'(GAP));
      chk("sw_done_kept", 32'(done_lost), 32'd0);
`else
      lowcnt    = 0;
      done_lost = 0;
`endif

      // random soak against the model
      for (int k = 0; k < 4000; k++) begin
         rst_n     = ($urandom_range(0, 999) != 0);
         init_done = ($urandom_range(0, 299) != 0);
         for (int b = 0; b < NUM_BANK; b++)
            bank[b] = ($urandom_range(0, 399) != 0);
         for (int p = 0; p < NUM_PLL; p++)
            lock[p] = ($urandom_range(0, 149) != 0);
         for (int c = 0; c < NUM_CH; c++)
            sw_req[c] = SW_EN && ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
